// File: rtl/hpdcache_pkg.sv
// ============================================================================
// Module      : hpdcache_pkg
// Description : Shared types and default geometry for the HPDcache refill path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hpdcache_pkg;

  localparam int unsigned HPDCACHE_SETS         = 64;
  localparam int unsigned HPDCACHE_WAYS         = 2;
  localparam int unsigned HPDCACHE_WORD_WIDTH   = 32;
  localparam int unsigned HPDCACHE_CL_WORDS     = 4;
  localparam int unsigned HPDCACHE_ACCESS_WORDS = 2;

  localparam int unsigned BEATS  = HPDCACHE_CL_WORDS / HPDCACHE_ACCESS_WORDS;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    COMMIT = 2'd2
  } refill_seq_state_e;

  // Beat entry for the default geometry; parameterised users build their own.
  typedef struct packed {
    logic [HPDCACHE_ACCESS_WORDS*HPDCACHE_WORD_WIDTH-1:0] data;
    logic                                                 error;
  } refill_beat_t;

  function automatic int unsigned calc_beat_w(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hpdcache_refill_beat_fifo.sv
// ============================================================================
// Module      : hpdcache_refill_beat_fifo
// Description : Synchronous beat FIFO with registered full/empty, no bypass.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hpdcache_refill_beat_fifo
  import hpdcache_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter type         ENTRY_T = refill_beat_t,
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
)(
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   push_i,
  input  ENTRY_T data_i,
  output logic   full_o,
  input  logic   pop_i,
  output ENTRY_T data_o,
  output logic   empty_o
);

  ENTRY_T           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             r_full, r_empty;
  logic             w_push, w_pop;

  assign w_push  = push_i & ~r_full;
  assign w_pop   = pop_i & ~r_empty;
  assign full_o  = r_full;
  assign empty_o = r_empty;
  assign data_o  = r_mem[r_rptr];

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_push && !w_pop)      w_cnt_next = r_cnt + 1'b1;
    else if (!w_push && w_pop) w_cnt_next = r_cnt - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= data_i;
  end

  // Flags are registered so a beat is never visible in the cycle it arrives.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) r_wptr <= (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      if (w_pop)  r_rptr <= (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
      r_cnt   <= w_cnt_next;
      r_full  <= (w_cnt_next == CNT_W'(DEPTH));
      r_empty <= (w_cnt_next == '0);
    end
  end

endmodule

`default_nettype wire

// File: rtl/hpdcache_refill_seq.sv
// ============================================================================
// Module      : hpdcache_refill_seq
// Description : Writes refill beats into the data RAM, then commits the
//               directory entry. HPDCACHE_REFILL_SEQ_STATS_EN adds counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hpdcache_refill_seq
  import hpdcache_pkg::*;
#(
  parameter int unsigned SETS          = HPDCACHE_SETS,
  parameter int unsigned WAYS          = HPDCACHE_WAYS,
  parameter int unsigned WORD_WIDTH    = HPDCACHE_WORD_WIDTH,
  parameter int unsigned CL_WORDS      = HPDCACHE_CL_WORDS,
  parameter int unsigned ACCESS_WORDS  = HPDCACHE_ACCESS_WORDS,
  parameter int unsigned FIFO_DEPTH    = 2,
  localparam int unsigned SET_W        = $clog2(SETS),
  localparam int unsigned LINE_BEATS   = CL_WORDS / ACCESS_WORDS,
  localparam int unsigned BEAT_IDX_W   = calc_beat_w(LINE_BEATS),
  localparam int unsigned BEAT_DATA_W  = ACCESS_WORDS * WORD_WIDTH
)(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   refill_valid_i,
  output logic                   refill_ready_o,
  input  logic [SET_W-1:0]       refill_set_i,
  input  logic [WAYS-1:0]        refill_way_i,
  input  logic                   mem_valid_i,
  output logic                   mem_ready_o,
  input  logic [BEAT_DATA_W-1:0] mem_data_i,
  input  logic                   mem_error_i,
  output logic                   ram_req_o,
  input  logic                   ram_gnt_i,
  output logic [SET_W-1:0]       ram_set_o,
  output logic [WAYS-1:0]        ram_way_o,
  output logic [BEAT_IDX_W-1:0]  ram_beat_o,
  output logic [BEAT_DATA_W-1:0] ram_wdata_o,
  output logic                   dir_valid_o,
  output logic [SET_W-1:0]       dir_set_o,
  output logic [WAYS-1:0]        dir_way_o,
  output logic                   error_o,
  output logic                   busy_o
`ifdef HPDCACHE_REFILL_SEQ_STATS_EN
  ,
  output logic [31:0]            stat_refills_o,
  output logic [31:0]            stat_errors_o,
  output logic [31:0]            stat_stall_o
`endif
);

  typedef struct packed {
    logic [BEAT_DATA_W-1:0] data;
    logic                   error;
  } beat_t;

  refill_seq_state_e     r_state, w_state_next;
  logic [SET_W-1:0]      r_set;
  logic [WAYS-1:0]       r_way;
  logic [BEAT_IDX_W-1:0] r_cnt;
  logic                  r_err;
  beat_t                 w_push_entry, w_head;
  logic                  w_full, w_empty, w_push, w_pop, w_last, w_accept;

  assign w_push             = mem_valid_i & ~w_full;
  assign w_push_entry.data  = mem_data_i;
  assign w_push_entry.error = mem_error_i;
  assign w_last             = (r_cnt == BEAT_IDX_W'(LINE_BEATS - 1));
  assign w_accept           = (r_state == IDLE) & refill_valid_i;

  hpdcache_refill_beat_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .ENTRY_T (beat_t)
  ) u_beat_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .data_i  (w_push_entry),
    .full_o  (w_full),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .empty_o (w_empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next   = r_state;
    refill_ready_o = 1'b0;
    ram_req_o      = 1'b0;
    w_pop          = 1'b0;
    dir_valid_o    = 1'b0;
    error_o        = 1'b0;
    case (r_state)
      IDLE: begin
        refill_ready_o = 1'b1;
        if (refill_valid_i) w_state_next = WRITE;
      end
      WRITE: begin
        ram_req_o = ~w_empty;
        w_pop     = ~w_empty & ram_gnt_i;
        if (w_pop && w_last) w_state_next = COMMIT;
      end
      COMMIT: begin
        // Errored lines are drained into the RAM but never made valid.
        dir_valid_o  = ~r_err;
        error_o      = r_err;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    ram_wdata_o = ram_req_o ? w_head.data : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_set <= '0;
      r_way <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_set <= refill_set_i;
      r_way <= refill_way_i;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (w_pop) begin
      r_err <= r_err | w_head.error;
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  assign mem_ready_o = ~w_full;
  assign ram_set_o   = r_set;
  assign ram_way_o   = r_way;
  assign ram_beat_o  = r_cnt;
  assign dir_set_o   = r_set;
  assign dir_way_o   = r_way;
  assign busy_o      = (r_state != IDLE);

`ifdef HPDCACHE_REFILL_SEQ_STATS_EN
  logic [31:0] r_stat_refills, r_stat_errors, r_stat_stall;

  // Saturating counters: they stick at all-ones rather than wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stat_refills <= '0;
      r_stat_errors  <= '0;
      r_stat_stall   <= '0;
    end else begin
      if (dir_valid_o && (r_stat_refills != '1)) r_stat_refills <= r_stat_refills + 32'd1;
      if (error_o && (r_stat_errors != '1))      r_stat_errors  <= r_stat_errors + 32'd1;
      if (ram_req_o && !ram_gnt_i && (r_stat_stall != '1))
        r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign stat_refills_o = r_stat_refills;
  assign stat_errors_o  = r_stat_errors;
  assign stat_stall_o   = r_stat_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hpdcache_refill_seq.sv
// ============================================================================
// Module      : tb_hpdcache_refill_seq
// Description : Self-checking bench: vector table, directed corner sequences
//               and a randomized run against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hpdcache_refill_seq;

  localparam int NC = 24;
  localparam int NR = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        refill_valid_i, refill_ready_o;
  logic [5:0]  refill_set_i;
  logic [1:0]  refill_way_i;
  logic        mem_valid_i, mem_ready_o, mem_error_i;
  logic [63:0] mem_data_i;
  logic        ram_req_o, ram_gnt_i;
  logic [5:0]  ram_set_o;
  logic [1:0]  ram_way_o;
  logic [0:0]  ram_beat_o;
  logic [63:0] ram_wdata_o;
  logic        dir_valid_o, error_o, busy_o;
  logic [5:0]  dir_set_o;
  logic [1:0]  dir_way_o;
`ifdef HPDCACHE_REFILL_SEQ_STATS_EN
  logic [31:0] stat_refills_o, stat_errors_o, stat_stall_o;
`endif

  hpdcache_refill_seq dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .refill_valid_i (refill_valid_i),
    .refill_ready_o (refill_ready_o),
    .refill_set_i   (refill_set_i),
    .refill_way_i   (refill_way_i),
    .mem_valid_i    (mem_valid_i),
    .mem_ready_o    (mem_ready_o),
    .mem_data_i     (mem_data_i),
    .mem_error_i    (mem_error_i),
    .ram_req_o      (ram_req_o),
    .ram_gnt_i      (ram_gnt_i),
    .ram_set_o      (ram_set_o),
    .ram_way_o      (ram_way_o),
    .ram_beat_o     (ram_beat_o),
    .ram_wdata_o    (ram_wdata_o),
    .dir_valid_o    (dir_valid_o),
    .dir_set_o      (dir_set_o),
    .dir_way_o      (dir_way_o),
    .error_o        (error_o),
    .busy_o         (busy_o)
`ifdef HPDCACHE_REFILL_SEQ_STATS_EN
    ,
    .stat_refills_o (stat_refills_o),
    .stat_errors_o  (stat_errors_o),
    .stat_stall_o   (stat_stall_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-cycle script: stimulus applied after the rising edge, outputs recorded at the falling edge.
  logic        s_rv [NC], s_mv [NC], s_me [NC], s_gnt [NC];
  logic [5:0]  s_set [NC];
  logic [1:0]  s_way [NC];
  logic [63:0] s_md [NC];
  logic        rec_req [NC], rec_dv [NC], rec_er [NC], rec_rdy [NC], rec_mrdy [NC];
  logic [0:0]  rec_beat [NC];
  logic [63:0] rec_data [NC];
  logic [5:0]  rec_dset [NC], rec_wset [NC];
  logic [1:0]  rec_dway [NC], rec_wway [NC];

  task automatic idle_inputs();
    refill_valid_i = 1'b0; refill_set_i = '0; refill_way_i = '0;
    mem_valid_i = 1'b0; mem_data_i = '0; mem_error_i = 1'b0; ram_gnt_i = 1'b1;
  endtask

  task automatic clear_script();
    for (int c = 0; c < NC; c++) begin
      s_rv[c] = 0; s_mv[c] = 0; s_me[c] = 0; s_gnt[c] = 1;
      s_set[c] = '0; s_way[c] = '0; s_md[c] = '0;
    end
  endtask

  task automatic run_script(input int n);
    for (int c = 0; c < n; c++) begin
      refill_valid_i = s_rv[c]; refill_set_i = s_set[c]; refill_way_i = s_way[c];
      mem_valid_i = s_mv[c]; mem_data_i = s_md[c]; mem_error_i = s_me[c]; ram_gnt_i = s_gnt[c];
      @(negedge clk_i);
      rec_req[c] = ram_req_o; rec_beat[c] = ram_beat_o; rec_data[c] = ram_wdata_o;
      rec_wset[c] = ram_set_o; rec_wway[c] = ram_way_o;
      rec_dv[c] = dir_valid_o; rec_er[c] = error_o; rec_dset[c] = dir_set_o; rec_dway[c] = dir_way_o;
      rec_rdy[c] = refill_ready_o; rec_mrdy[c] = mem_ready_o;
      @(posedge clk_i); #1;
    end
    idle_inputs();
  endtask

  typedef struct {
    logic [5:0]  set;
    logic [1:0]  way;
    logic [63:0] d0, d1;
    logic        e0, e1;
    int          stall;
    int          cw0, cw1, cc;
    logic        dv, er;
  } vec_t;

  vec_t tbl [5];

  task automatic run_vec(input vec_t v, input int id);
    int w [2];
    int nw, cc, np, c0, c1;
    logic ok;
    clear_script();
    s_rv[0] = 1; s_set[0] = v.set; s_way[0] = v.way;
    s_mv[1] = 1; s_md[1] = v.d0; s_me[1] = v.e0;
    s_mv[2] = 1; s_md[2] = v.d1; s_me[2] = v.e1;
    for (int c = 2; c < 2 + v.stall; c++) s_gnt[c] = 0;
    run_script(14);
    w[0] = -1; w[1] = -1; nw = 0; cc = -1; np = 0;
    for (int c = 0; c < 14; c++) begin
      if (rec_req[c] && s_gnt[c]) begin
        if (nw < 2) w[nw] = c;
        nw++;
      end
      if (rec_dv[c] || rec_er[c]) begin
        if (cc < 0) cc = c;
        np++;
      end
    end
    c0 = (w[0] < 0) ? 0 : w[0];
    c1 = (w[1] < 0) ? 0 : w[1];
    chk($sformatf("v%0d_ready_c0", id), rec_rdy[0], 1);
    chk($sformatf("v%0d_nwrites", id), nw, 2);
    chk($sformatf("v%0d_w0_cycle", id), w[0], v.cw0);
    chk($sformatf("v%0d_w0_data", id), rec_data[c0], v.d0);
    chk($sformatf("v%0d_w0_addr", id), {rec_wset[c0], rec_wway[c0], rec_beat[c0]}, {v.set, v.way, 1'b0});
    chk($sformatf("v%0d_w1_cycle", id), w[1], v.cw1);
    chk($sformatf("v%0d_w1_data", id), rec_data[c1], v.d1);
    chk($sformatf("v%0d_w1_addr", id), {rec_wset[c1], rec_wway[c1], rec_beat[c1]}, {v.set, v.way, 1'b1});
    chk($sformatf("v%0d_commit_cycle", id), cc, v.cc);
    chk($sformatf("v%0d_npulses", id), np, 1);
    if (cc >= 0)
      chk($sformatf("v%0d_commit", id), {rec_dv[cc], rec_er[cc], rec_dset[cc], rec_dway[cc]},
          {v.dv, v.er, v.set, v.way});
    if (v.stall > 0) begin
      ok = 1;
      for (int c = 2; c < 2 + v.stall; c++)
        ok &= rec_req[c] && (rec_data[c] == v.d0) && (rec_beat[c] == 1'b0);
      chk($sformatf("v%0d_stall_hold", id), ok, 1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, {refill_ready_o, mem_ready_o, ram_req_o, dir_valid_o, error_o, busy_o}, 6'b110000);
    chk({tag, "_addr"}, {ram_set_o, ram_way_o, ram_beat_o, dir_set_o, dir_way_o}, 0);
    chk({tag, "_wdata"}, ram_wdata_o, 0);
`ifdef HPDCACHE_REFILL_SEQ_STATS_EN
    chk({tag, "_stats"}, {stat_refills_o, stat_errors_o} | {32'd0, stat_stall_o}, 0);
`endif
  endtask

  // Randomized run checked against a transaction-level expectation of writes and commits.
  typedef struct { logic [5:0] set; logic [1:0] way; logic [0:0] beat; logic [63:0] data; } wr_t;
  typedef struct { logic [5:0] set; logic [1:0] way; logic err; } cm_t;

  task automatic random_test();
    logic [5:0]  rs [NR];
    logic [1:0]  rw [NR];
    logic [63:0] rd [2*NR];
    logic        re [2*NR];
    wr_t ew [$];
    cm_t ec [$];
    wr_t w;
    cm_t m;
    int done, commits, cyc;
    for (int r = 0; r < NR; r++) begin
      rs[r] = 6'($urandom);
      rw[r] = 2'b01 << $urandom_range(0, 1);
      for (int b = 0; b < 2; b++) begin
        rd[2*r+b] = {$urandom, $urandom};
        re[2*r+b] = ($urandom_range(0, 5) == 0);
        ew.push_back('{set: rs[r], way: rw[r], beat: 1'(b), data: rd[2*r+b]});
      end
      ec.push_back('{set: rs[r], way: rw[r], err: re[2*r] | re[2*r+1]});
    end
    done = 0; commits = 0; cyc = 0;
    fork
      begin
        for (int r = 0; r < NR; r++) begin
          int t;
          refill_valid_i = 1; refill_set_i = rs[r]; refill_way_i = rw[r];
          t = 0;
          do begin @(negedge clk_i); t++; end while (!refill_ready_o && t < 300);
          @(posedge clk_i); #1;
          refill_valid_i = 0;
          repeat ($urandom_range(0, 3)) begin @(posedge clk_i); #1; end
        end
      end
      begin
        for (int k = 0; k < 2 * NR; k++) begin
          int t;
          repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
          mem_valid_i = 1; mem_data_i = rd[k]; mem_error_i = re[k];
          t = 0;
          do begin @(negedge clk_i); t++; end while (!mem_ready_o && t < 300);
          @(posedge clk_i); #1;
          mem_valid_i = 0;
        end
      end
      begin
        while (done == 0) begin
          ram_gnt_i = ($urandom_range(0, 3) != 0);
          @(posedge clk_i); #1;
        end
        ram_gnt_i = 1;
      end
      begin
        while (commits < NR && cyc < 4000) begin
          @(negedge clk_i);
          cyc++;
          if (ram_req_o && ram_gnt_i) begin
            if (ew.size() == 0) chk("rand_extra_write", 1, 0);
            else begin
              w = ew.pop_front();
              chk("rand_wdata", ram_wdata_o, w.data);
              chk("rand_waddr", {ram_set_o, ram_way_o, ram_beat_o}, {w.set, w.way, w.beat});
            end
          end
          if (dir_valid_o || error_o) begin
            if (ec.size() == 0) chk("rand_extra_commit", 1, 0);
            else begin
              m = ec.pop_front();
              chk("rand_commit", {dir_set_o, dir_way_o, error_o, dir_valid_o},
                  {m.set, m.way, m.err, ~m.err});
            end
            commits++;
          end
        end
        done = 1;
      end
    join
    chk("rand_commits", commits, NR);
    chk("rand_writes_left", ew.size(), 0);
  endtask

  initial begin
    idle_inputs();
    tbl[0] = '{set: 6'h2A, way: 2'b10, d0: 64'hAAAA_BBBB_CCCC_DDDD, d1: 64'h1111_2222_3333_4444,
               e0: 0, e1: 0, stall: 0, cw0: 2, cw1: 3, cc: 4, dv: 1, er: 0};
    tbl[1] = '{set: 6'h15, way: 2'b01, d0: 64'h0123_4567_89AB_CDEF, d1: 64'hFEDC_BA98_7654_3210,
               e0: 0, e1: 0, stall: 3, cw0: 5, cw1: 6, cc: 7, dv: 1, er: 0};
    tbl[2] = '{set: 6'h3F, way: 2'b10, d0: 64'hDEAD_BEEF_0000_0001, d1: 64'hCAFE_F00D_0000_0002,
               e0: 0, e1: 1, stall: 0, cw0: 2, cw1: 3, cc: 4, dv: 0, er: 1};
    tbl[3] = '{set: 6'h00, way: 2'b01, d0: 64'h5555_5555_5555_5555, d1: 64'hAAAA_AAAA_AAAA_AAAA,
               e0: 0, e1: 0, stall: 0, cw0: 2, cw1: 3, cc: 4, dv: 1, er: 0};
    tbl[4] = '{set: 6'h21, way: 2'b10, d0: 64'h0F0F_0F0F_0F0F_0F0F, d1: 64'hF0F0_F0F0_F0F0_F0F0,
               e0: 1, e1: 0, stall: 1, cw0: 3, cw1: 4, cc: 5, dv: 0, er: 1};

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_reset_outputs("reset");
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    for (int i = 0; i < 5; i++) begin
      run_vec(tbl[i], i);
`ifdef HPDCACHE_REFILL_SEQ_STATS_EN
      if (i == 1) chk("stat_stall_after_v1", stat_stall_o, 3);
`endif
    end
`ifdef HPDCACHE_REFILL_SEQ_STATS_EN
    chk("stat_refills", stat_refills_o, 3);
    chk("stat_errors", stat_errors_o, 2);
    chk("stat_stall", stat_stall_o, 4);
`endif

    // Early data: both beats land while idle, command follows later.
    clear_script();
    s_mv[0] = 1; s_md[0] = 64'h1234_0000_0000_0001;
    s_mv[1] = 1; s_md[1] = 64'h1234_0000_0000_0002;
    s_rv[6] = 1; s_set[6] = 6'h0C; s_way[6] = 2'b01;
    run_script(12);
    chk("early_mrdy_c1", rec_mrdy[1], 1);
    chk("early_mrdy_full", rec_mrdy[2], 0);
    chk("early_w0", {rec_req[7], rec_beat[7], rec_data[7]}, {1'b1, 1'b0, 64'h1234_0000_0000_0001});
    chk("early_mrdy_after_pop", rec_mrdy[8], 1);
    chk("early_w1", {rec_req[8], rec_beat[8], rec_data[8]}, {1'b1, 1'b1, 64'h1234_0000_0000_0002});
    chk("early_commit", {rec_dv[9], rec_dset[9], rec_dway[9]}, {1'b1, 6'h0C, 2'b01});

    // Back-to-back commands: second held valid until accepted.
    clear_script();
    s_rv[0] = 1; s_set[0] = 6'h05; s_way[0] = 2'b01;
    for (int c = 1; c < 6; c++) begin s_rv[c] = 1; s_set[c] = 6'h06; s_way[c] = 2'b10; end
    s_mv[1] = 1; s_md[1] = 64'hA0; s_mv[2] = 1; s_md[2] = 64'hA1;
    s_mv[3] = 1; s_md[3] = 64'hB0; s_mv[4] = 1; s_md[4] = 64'hB1;
    run_script(12);
    chk("b2b_ready_busy", {rec_rdy[0], rec_rdy[1], rec_rdy[2], rec_rdy[3], rec_rdy[4], rec_rdy[5]}, 6'b100001);
    chk("b2b_commit_a", {rec_dv[4], rec_dset[4], rec_dway[4]}, {1'b1, 6'h05, 2'b01});
    chk("b2b_w_b0", {rec_req[6], rec_wset[6], rec_data[6]}, {1'b1, 6'h06, 64'hB0});
    chk("b2b_commit_b", {rec_dv[8], rec_dset[8], rec_dway[8]}, {1'b1, 6'h06, 2'b10});

    // Reset after the first RAM write of a refill.
    clear_script();
    s_rv[0] = 1; s_set[0] = 6'h11; s_way[0] = 2'b01;
    s_mv[1] = 1; s_md[1] = 64'h77; s_mv[2] = 1; s_md[2] = 64'h88;
    run_script(3);
    chk("rst_first_write", {rec_req[2], rec_data[2]}, {1'b1, 64'h77});
    #1 rst_ni = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    clear_script();
    run_script(8);
    begin
      logic any;
      any = 0;
      for (int c = 0; c < 8; c++) any |= rec_req[c] | rec_dv[c] | rec_er[c] | ~rec_mrdy[c];
      chk("midrst_quiet", any, 0);
    end
    run_vec(tbl[0], 9);

    random_test();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/hpdcache_refill_seq.md
Name: hpdcache_refill_seq

Overview:
- Sequences a cache-line refill from the memory read-response channel into the HPDcache data RAM, then commits the directory entry.
- Accepts one refill command (set, way) from the miss handler.
- Buffers incoming response beats in a small FIFO and issues one data-RAM write per beat; each write must win arbitration against the core pipeline.
- Sits between the memory response interface and the data/directory arrays, beside the MSHR.

Parameters:
- SETS, 64: cache sets; SET_W = $clog2(SETS).
- WAYS, 2: cache ways; way select is one-hot.
- WORD_WIDTH, 32: bits per word.
- CL_WORDS, 4: words per cache line.
- ACCESS_WORDS, 2: words per memory beat and per RAM write. BEATS = CL_WORDS/ACCESS_WORDS; BEAT_W = max(1, $clog2(BEATS)).
- FIFO_DEPTH, 2: depth of the response beat FIFO, minimum 1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- refill_valid_i  in  1  refill command valid.
- refill_ready_o  out  1  command accepted; high only in IDLE.
- refill_set_i  in  SET_W  target set.
- refill_way_i  in  WAYS  target way, one-hot.
- mem_valid_i  in  1  response beat valid.
- mem_ready_o  out  1  FIFO not full.
- mem_data_i  in  ACCESS_WORDS*WORD_WIDTH  beat data.
- mem_error_i  in  1  beat carries a bus error.
- ram_req_o  out  1  data-RAM write request.
- ram_gnt_i  in  1  arbiter grant; write happens in the cycle where req and gnt are both high.
- ram_set_o  out  SET_W  write set.
- ram_way_o  out  WAYS  write way.
- ram_beat_o  out  BEAT_W  beat index within the line.
- ram_wdata_o  out  ACCESS_WORDS*WORD_WIDTH  write data.
- dir_valid_o  out  1  one-cycle directory commit pulse.
- dir_set_o  out  SET_W  commit set.
- dir_way_o  out  WAYS  commit way.
- error_o  out  1  one-cycle pulse: refill aborted because a beat had an error.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset state: FSM=IDLE, FIFO empty, beat counter=0, sticky error flag=0. All outputs 0 except mem_ready_o=1 and refill_ready_o=1.
- IDLE:
  - refill_valid_i & refill_ready_o latches set/way, clears counter and error flag, moves to WRITE.
  - The accept handshake is the next state transition. The command is taken in the cycle of the handshake.
- WRITE:
  - ram_req_o = FIFO not empty. ram_wdata_o = FIFO head. ram_beat_o = counter.
  - On ram_req_o & ram_gnt_i: pop the FIFO, OR the head's error bit into the flag, increment the counter.
  - On the last beat (counter == BEATS-1) go to COMMIT and reset the counter to 0.
  - If ram_gnt_i is low, hold the request and do not pop. Outputs stay stable while req is high without gnt.
- COMMIT, exactly one cycle:
  - Error flag=0: dir_valid_o=1 with latched set/way.
  - Error flag=1: error_o=1, dir_valid_o=0. Beats are still written so the protocol drains; the line stays invalid.
  - Return to IDLE.
- FIFO:
  - Depth FIFO_DEPTH; each entry holds data + error bit.
  - Push on mem_valid_i & mem_ready_o. Pushes are accepted in any state, including IDLE, because memory may return data early.
  - Simultaneous push and pop when full is not allowed: mem_ready_o depends only on the registered full flag.
  - Simultaneous push and pop when non-empty keeps the count unchanged.
  - Pop of a beat pushed in the same cycle is not permitted; the FIFO has no bypass, so RAM-write latency is at least 1 cycle after the beat is pushed.
- Latency, zero-wait (gnt tied high, beats back-to-back): command accepted at cycle 0, last RAM write at cycle BEATS+1, dir_valid_o at cycle BEATS+2. With defaults (BEATS=2): dir_valid_o at cycle 4.
- A refill command is not accepted in COMMIT; refill_ready_o is low there.
- Asynchronous reset mid-refill drops the FIFO contents and the command with no commit and no error pulse.

Optional Feature:
- Macro HPDCACHE_REFILL_SEQ_STATS_EN.
- When defined, add three outputs:
  - stat_refills_o: 32-bit count of completed commits (dir_valid_o pulses).
  - stat_errors_o: 32-bit count of error_o pulses.
  - stat_stall_o: 32-bit count of cycles with ram_req_o & !ram_gnt_i.
- Counters reset to 0, saturate at all-ones, and never wrap.
- When not defined, the ports and logic are absent and the block behaves identically otherwise.

Decomposition:
- hpdcache_pkg (shared package):
  - refill_seq_state_e enum {IDLE, WRITE, COMMIT}.
  - typedef for the beat entry struct {data, error}.
  - Localparams BEATS and BEAT_W.
- Sub-module hpdcache_refill_beat_fifo: parameterised-depth sync FIFO holding beat entries, with full/empty flags and no bypass.

Test Plan:
- Nominal, gnt=1, set=0x2A, way=2'b10, beats 0xAAAA_BBBB_CCCC_DDDD then 0x1111_2222_3333_4444 back-to-back:
  - Writes at cycles 2 and 3 with ram_beat_o 0,1 and matching data.
  - dir_valid_o at cycle 4 with set 0x2A, way 2'b10.
- Arbitration stall, gnt low for 3 cycles on beat 0:
  - ram_req_o held with stable data/beat.
  - stat_stall_o=3 (macro on).
  - Commit delayed by 3 cycles.
- Early data: 2 beats pushed while IDLE, command arrives 5 cycles later:
  - mem_ready_o=0 after the 2nd push.
  - Writes proceed immediately after command accept.
  - mem_ready_o returns to 1 after the first pop.
- Error on beat 1:
  - Both beats are written.
  - error_o pulses at COMMIT; dir_valid_o stays 0.
  - Next refill is accepted and commits normally; the error flag is cleared.
- Reset asserted after the first RAM write:
  - All outputs return to reset values; FIFO empty.
  - No dir_valid_o or error_o pulse.
  - A new refill completes correctly afterwards.
- Back-to-back commands:
  - refill_ready_o low during WRITE and COMMIT.
  - Second command accepted the cycle after COMMIT returns to IDLE.
